// File: rtl/cube_frame_sequencer_if.sv
// cube_frame_sequencer_if: CPU control, cube_raster status and frame-level
// outputs of the frame sequencer, bundled as one interface.
// master = CPU/raster side driving the inputs, slave = sequencer.
interface cube_frame_sequencer_if #(
   parameter int FRAME_CNT_W = 8
);
   logic                   start;
   logic                   repeat_en;
   logic                   abort;
   logic                   clear_err;
   logic                   finished_in;
   logic                   drq_in;
   logic                   raster_rst_n;
   logic                   drq_out;
   logic                   sout_en;
   logic                   busy;
   logic                   frame_done;
   logic [FRAME_CNT_W-1:0] frame_count;
   logic                   err;

   modport master (
      output start, repeat_en, abort, clear_err, finished_in, drq_in,
      input  raster_rst_n, drq_out, sout_en, busy, frame_done, frame_count, err
   );

   modport slave (
      input  start, repeat_en, abort, clear_err, finished_in, drq_in,
      output raster_rst_n, drq_out, sout_en, busy, frame_done, frame_count, err
   );
endinterface

// File: rtl/cube_frame_sequencer.sv
// cube_frame_sequencer: frame-level supervisor for cube_raster.
// IDLE -> RUN on start, RUN -> LATCH on finished/abort, LATCH holds the raster
// in reset with LED lines low for LATCH_CYCLES, then restarts or idles.
// Optional frame watchdog (RUN -> ERROR) built when CUBE_SEQ_WATCHDOG_EN is defined.
// All outputs are registered from the next state, so they line up with the
// state the sequencer is in during that cycle.
module cube_frame_sequencer #(
   parameter int LATCH_CYCLES  = 1200,
   parameter int CNT_W         = 16,
   parameter int FRAME_CNT_W   = 8,
   parameter int FRAME_TIMEOUT = 60000
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   cube_frame_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_LATCH = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       lcnt_q, lcnt_d;
   logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
   logic                   raster_q, sout_q, drq_q, busy_q, fd_q, err_q;

`ifdef CUBE_SEQ_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(FRAME_TIMEOUT - 1);
   logic [CNT_W-1:0] wd_q, wd_d;
`else
   // Watchdog absent: clear_err and the timeout have no function.
   localparam int unused_timeout = FRAME_TIMEOUT;
   logic unused_clear_err;
   assign unused_clear_err = bus.clear_err;
`endif

   // Next-state, latch-gap counter and frame counter.
   always_comb begin
      state_d = state_q;
      lcnt_d  = lcnt_q;
      fcnt_d  = fcnt_q;
`ifdef CUBE_SEQ_WATCHDOG_EN
      wd_d    = wd_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d = S_RUN;
`ifdef CUBE_SEQ_WATCHDOG_EN
               wd_d    = '0;
`endif
            end
         end
         S_RUN: begin
`ifdef CUBE_SEQ_WATCHDOG_EN
            wd_d = wd_q + 1'b1;
`endif
            // finished beats both timeout and abort on the same cycle
            if (bus.finished_in) begin
               state_d = S_LATCH;
               lcnt_d  = LATCH_LOAD;
               fcnt_d  = fcnt_q + 1'b1;
            end
`ifdef CUBE_SEQ_WATCHDOG_EN
            else if (wd_q == WD_LAST) begin
               state_d = S_ERROR;
            end
`endif
            else if (bus.abort) begin
               state_d = S_LATCH;
               lcnt_d  = LATCH_LOAD;
            end
         end
         S_LATCH: begin
            // abort never shortens the gap, it only vetoes the restart
            if (lcnt_q == '0) begin
               if (bus.repeat_en && !bus.abort) begin
                  state_d = S_RUN;
`ifdef CUBE_SEQ_WATCHDOG_EN
                  wd_d    = '0;
`endif
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               lcnt_d = lcnt_q - 1'b1;
            end
         end
`ifdef CUBE_SEQ_WATCHDOG_EN
         S_ERROR: begin
            if (bus.clear_err) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State/counter registers and registered outputs derived from next state.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q  <= S_IDLE;
         lcnt_q   <= '0;
         fcnt_q   <= '0;
         raster_q <= 1'b0;
         sout_q   <= 1'b0;
         drq_q    <= 1'b0;
         busy_q   <= 1'b0;
         fd_q     <= 1'b0;
         err_q    <= 1'b0;
`ifdef CUBE_SEQ_WATCHDOG_EN
         wd_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         lcnt_q   <= lcnt_d;
         fcnt_q   <= fcnt_d;
         raster_q <= (state_d == S_RUN);
         sout_q   <= (state_d == S_RUN);
         drq_q    <= (state_d == S_RUN) && bus.drq_in;
         busy_q   <= (state_d != S_IDLE);
         // high during the last gap cycle (counter at zero)
         fd_q     <= (state_d == S_LATCH) && (lcnt_d == '0);
`ifdef CUBE_SEQ_WATCHDOG_EN
         err_q    <= (state_d == S_ERROR);
         wd_q     <= wd_d;
`else
         err_q    <= 1'b0;
`endif
      end
   end

   assign bus.raster_rst_n = raster_q;
   assign bus.sout_en      = sout_q;
   assign bus.drq_out      = drq_q;
   assign bus.busy         = busy_q;
   assign bus.frame_done   = fd_q;
   assign bus.frame_count  = fcnt_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_cube_frame_sequencer.sv
// Bench for cube_frame_sequencer: one task per scenario, frame_done checked
// against a queue of expected frame_count values pushed when finish/abort
// is driven.
module tb_cube_frame_sequencer;
   localparam int LC = 4;
   localparam int FW = 8;
   localparam int FT = 50;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cube_frame_sequencer_if #(.FRAME_CNT_W(FW)) bus ();

   cube_frame_sequencer #(
      .LATCH_CYCLES(LC), .CNT_W(16), .FRAME_CNT_W(FW), .FRAME_TIMEOUT(FT)
   ) dut (
      .clk_i(clk), .reset_i(reset), .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   logic [FW-1:0] model = '0;
   logic [FW-1:0] exp_q[$];

   // frame_done scoreboard: each pulse must match the oldest pending frame
   always @(negedge clk) begin
      if (bus.frame_done === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_done_unexpected: got pulse with frame_count=%0d, expected none", bus.frame_count);
         end else begin
            logic [FW-1:0] e;
            e = exp_q.pop_front();
            if (bus.frame_count !== e) begin
               errors++;
               $display("FAIL frame_done_count: got %0d expected %0d", bus.frame_count, e);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (bus.busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.start = 0; bus.repeat_en = 0; bus.abort = 0;
      bus.clear_err = 0; bus.finished_in = 0; bus.drq_in = 0;
      step(); step();
      reset = 1'b1;
      model = '0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      bit ok;
      do_reset();
      checks++;
      if ({bus.raster_rst_n, bus.drq_out, bus.sout_en, bus.busy, bus.frame_done, bus.err} !== 6'b0 ||
          bus.frame_count !== '0) begin
         errors++;
         $display("FAIL reset_init: got outs=%b cnt=%0d expected 0/0",
                  {bus.raster_rst_n, bus.drq_out, bus.sout_en, bus.busy, bus.frame_done, bus.err}, bus.frame_count);
      end
      // one frame so frame_count is nonzero before the mid-run reset
      bus.start = 1; step(); bus.start = 0;
      bus.finished_in = 1; model++; exp_q.push_back(model); step(); bus.finished_in = 0;
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_prep_idle: got busy=%b expected 0", bus.busy); end
      bus.start = 1; bus.drq_in = 1; step(); bus.start = 0;
      checks++;
      if (bus.busy !== 1'b1 || bus.frame_count !== 8'd1) begin
         errors++;
         $display("FAIL reset_prep_run: got busy=%b cnt=%0d expected 1/1", bus.busy, bus.frame_count);
      end
      step();
      reset = 1'b0; step();
      checks++;
      if ({bus.raster_rst_n, bus.drq_out, bus.sout_en, bus.busy, bus.frame_done, bus.err} !== 6'b0 ||
          bus.frame_count !== '0) begin
         errors++;
         $display("FAIL reset_midrun: got outs=%b cnt=%0d expected 0/0",
                  {bus.raster_rst_n, bus.drq_out, bus.sout_en, bus.busy, bus.frame_done, bus.err}, bus.frame_count);
      end
      step();
      reset = 1'b1; bus.drq_in = 0; model = '0;
      step();
      checks++;
      if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_after: got busy=%b pending=%0d expected 0/0", bus.busy, exp_q.size());
      end
   endtask

   task automatic test_single_frame();
      do_reset();
      bus.start = 1; step(); bus.start = 0;
      checks++;
      if (bus.raster_rst_n !== 1'b1 || bus.sout_en !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_run_entry: got rst_n=%b sout=%b busy=%b expected 111",
                  bus.raster_rst_n, bus.sout_en, bus.busy);
      end
      repeat (99) step();
      checks++;
      if (bus.sout_en !== 1'b1) begin errors++; $display("FAIL single_run_hold: got sout=%b expected 1", bus.sout_en); end
      bus.finished_in = 1; model++; exp_q.push_back(model); step(); bus.finished_in = 0;
      for (int i = 0; i < LC; i++) begin
         checks++;
         if (bus.sout_en !== 1'b0 || bus.busy !== 1'b1 || bus.raster_rst_n !== 1'b0 ||
             bus.frame_done !== (i == LC - 1)) begin
            errors++;
            $display("FAIL single_latch_%0d: got sout=%b busy=%b rst_n=%b fd=%b expected 0 1 0 %b",
                     i, bus.sout_en, bus.busy, bus.raster_rst_n, bus.frame_done, (i == LC - 1));
         end
         bus.start = (i == 1);   // start while busy must be dropped
         step();
      end
      bus.start = 0;
      checks++;
      if (bus.busy !== 1'b0 || bus.frame_count !== 8'd1) begin
         errors++;
         $display("FAIL single_idle: got busy=%b cnt=%0d expected 0/1", bus.busy, bus.frame_count);
      end
      bus.start = 1; bus.abort = 1; step(); bus.start = 0; bus.abort = 0;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle: got busy=%b expected 0", bus.busy); end
   endtask

   task automatic test_repeat_wrap();
      bit ok;
      int gaps;
      gaps = 0;
      do_reset();
      bus.repeat_en = 1; bus.finished_in = 1;
      bus.start = 1; step(); bus.start = 0;
      for (int f = 0; f < 300; f++) begin
         ok = 1'b0;
         for (int c = 0; c < 10; c++) begin
            if (bus.sout_en === 1'b1) begin ok = 1'b1; break; end
            step();
         end
         if (!ok) begin
            checks++; errors++;
            $display("FAIL repeat_run_wait: got no RUN in frame %0d expected RUN", f);
            break;
         end
         model++; exp_q.push_back(model);
         step();
         if (f == 299) bus.repeat_en = 0;
         ok = 1'b0;
         for (int c = 0; c < 10; c++) begin
            if (bus.frame_done === 1'b1) begin ok = 1'b1; break; end
            step();
         end
         if (!ok) begin
            checks++; errors++;
            $display("FAIL repeat_fd_wait: got no frame_done in frame %0d expected pulse", f);
            break;
         end
         step();
         if (f < 299 && (bus.sout_en !== 1'b1 || bus.busy !== 1'b1)) gaps++;
      end
      bus.finished_in = 0;
      checks++;
      if (gaps != 0) begin errors++; $display("FAIL repeat_no_gap: got %0d gaps expected 0", gaps); end
      checks++;
      if (bus.busy !== 1'b0 || bus.frame_count !== 8'd44) begin
         errors++;
         $display("FAIL repeat_wrap: got busy=%b cnt=%0d expected 0/44", bus.busy, bus.frame_count);
      end
   endtask

   task automatic test_finish_abort();
      bit ok;
      int lat;
      do_reset();
      bus.repeat_en = 1;
      bus.start = 1; step(); bus.start = 0;
      step();
      bus.finished_in = 1; bus.abort = 1; model++; exp_q.push_back(model);
      step();
      bus.finished_in = 0;
      checks++;
      if (bus.sout_en !== 1'b0 || bus.frame_count !== model) begin
         errors++;
         $display("FAIL fin_abort_count: got sout=%b cnt=%0d expected 0/%0d", bus.sout_en, bus.frame_count, model);
      end
      // abort held across the rest of the gap with repeat_en=1
      for (lat = 1; lat < 20; lat++) begin
         step();
         if (!(bus.sout_en === 1'b0 && bus.busy === 1'b1)) break;
      end
      bus.abort = 0;
      checks++;
      if (lat != LC || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL latch_abort_gap: got len=%0d busy=%b expected %0d/0", lat, bus.busy, LC);
      end
      bus.repeat_en = 0;
      bus.start = 1; step(); bus.start = 0;
      bus.abort = 1; exp_q.push_back(model); step(); bus.abort = 0;
      checks++;
      if (bus.sout_en !== 1'b0 || bus.busy !== 1'b1 || bus.frame_count !== model) begin
         errors++;
         $display("FAIL run_abort: got sout=%b busy=%b cnt=%0d expected 0 1 %0d",
                  bus.sout_en, bus.busy, bus.frame_count, model);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL run_abort_idle: got busy=%b expected 0", bus.busy); end
   endtask

   task automatic test_drq();
      bit ok;
      int bad_run, bad_off;
      bad_run = 0; bad_off = 0;
      do_reset();
      bus.drq_in = 1;
      step();
      if (bus.drq_out !== 1'b0) bad_off++;
      bus.start = 1; step(); bus.start = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.drq_out !== 1'b1) bad_run++;
         step();
      end
      bus.drq_in = 0; step();
      checks++;
      if (bus.drq_out !== 1'b0 || bus.sout_en !== 1'b1) begin
         errors++;
         $display("FAIL drq_follow_low: got drq=%b sout=%b expected 0/1", bus.drq_out, bus.sout_en);
      end
      bus.drq_in = 1; step();
      if (bus.drq_out !== 1'b1) bad_run++;
      bus.finished_in = 1; model++; exp_q.push_back(model); step(); bus.finished_in = 0;
      for (int i = 0; i < LC + 3; i++) begin
         if (bus.drq_out !== 1'b0) bad_off++;
         step();
      end
      checks++;
      if (bad_run != 0) begin errors++; $display("FAIL drq_run: got %0d low cycles expected 0", bad_run); end
      checks++;
      if (bad_off != 0) begin errors++; $display("FAIL drq_off: got %0d high cycles expected 0", bad_off); end
      wait_idle(ok);
      bus.drq_in = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL drq_idle: got busy=%b expected 0", bus.busy); end
   endtask

   task automatic test_watchdog();
      bit ok;
      int runc;
      do_reset();
`ifdef CUBE_SEQ_WATCHDOG_EN
      bus.start = 1; step(); bus.start = 0;
      runc = 0;
      for (int c = 0; c < 100; c++) begin
         if (bus.sout_en !== 1'b1) break;
         runc++;
         step();
      end
      checks++;
      if (runc != FT) begin errors++; $display("FAIL wd_run_len: got %0d expected %0d", runc, FT); end
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b1 || bus.raster_rst_n !== 1'b0 ||
          bus.frame_done !== 1'b0 || bus.frame_count !== '0) begin
         errors++;
         $display("FAIL wd_error_state: got err=%b busy=%b rst_n=%b fd=%b cnt=%0d expected 1 1 0 0 0",
                  bus.err, bus.busy, bus.raster_rst_n, bus.frame_done, bus.frame_count);
      end
      bus.start = 1; step(); bus.start = 0; step();
      checks++;
      if (bus.err !== 1'b1 || bus.sout_en !== 1'b0) begin
         errors++;
         $display("FAIL wd_start_ignored: got err=%b sout=%b expected 1/0", bus.err, bus.sout_en);
      end
      bus.clear_err = 1; step(); bus.clear_err = 0;
      checks++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL wd_clear: got err=%b busy=%b expected 0/0", bus.err, bus.busy);
      end
      // finished on the timeout cycle wins
      bus.start = 1; step(); bus.start = 0;
      repeat (FT - 1) step();
      bus.finished_in = 1; model++; exp_q.push_back(model); step(); bus.finished_in = 0;
      checks++;
      if (bus.err !== 1'b0 || bus.sout_en !== 1'b0 || bus.frame_count !== model) begin
         errors++;
         $display("FAIL wd_finish_wins: got err=%b sout=%b cnt=%0d expected 0 0 %0d",
                  bus.err, bus.sout_en, bus.frame_count, model);
      end
`else
      runc = 0;
      bus.start = 1; step(); bus.start = 0;
      repeat (FT + 10) step();
      bus.clear_err = 1; step(); bus.clear_err = 0;
      checks++;
      if (bus.err !== 1'b0 || bus.sout_en !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL nowd_long_run: got err=%b sout=%b busy=%b expected 0 1 1",
                  bus.err, bus.sout_en, bus.busy);
      end
      bus.abort = 1; exp_q.push_back(model); step(); bus.abort = 0;
`endif
      wait_idle(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wd_end_idle: got busy=%b expected 0 (runs=%0d)", bus.busy, runc); end
   endtask

   initial begin
      bus.start = 0; bus.repeat_en = 0; bus.abort = 0;
      bus.clear_err = 0; bus.finished_in = 0; bus.drq_in = 0;
      test_reset();
      test_single_frame();
      test_repeat_wrap();
      test_finish_abort();
      test_drq();
      test_watchdog();
      step(); step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_frames: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
